dot2_q88: RTL and testbench
===========================

Name: dot2_q88

Overview:
- Pipelined two-element signed fixed-point dot product: c = a0*b0 + a1*b1.
- Default format is Q8.8 (16-bit two's complement, 8 fractional bits).
- Used as the row-by-column kernel for 1x2 by 2x1 matrix multiplication in the datapath.
- Streams one result per clock with a valid strobe, round-to-nearest and saturation.

Parameters:
- W, 16: total word width of every operand and of the result.
- FRAC, 8: fractional bits (Q(W-FRAC).FRAC). Requires 1 <= FRAC < W.
- SAT, 1: 1 = saturate on overflow; 0 = wrap (keep low W bits). The ovf flag is produced in both cases.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: operands valid this cycle.
- a0, input, W: row element 0, signed.
- a1, input, W: row element 1, signed.
- b0, input, W: column element 0, signed.
- b1, input, W: column element 1, signed.
- out_valid, output, 1: c and ovf hold a new result.
- c, output, W: signed result, same Q format as the inputs.
- ovf, output, 1: result exceeded the W-bit range and was saturated (SAT=1) or wrapped (SAT=0).

Behaviour:
- Reset (rst=1 at a rising edge): out_valid=0, c=0, ovf=0, stage-1 valid=0.
  - Results in flight are discarded; no out_valid is produced for them.
  - rst has priority over in_valid in the same cycle.
- No backpressure. Fully pipelined; accepts a new operand set every cycle.
- Latency 2 clocks. Operands sampled at edge k with in_valid=1 produce c and out_valid=1 after edge k+1.
- Stage 1 (edge k):
  - p0 = a0*b0 and p1 = a1*b1, full 2W-bit signed products in Q(2W-2FRAC).(2FRAC).
  - Registered together with v1 = in_valid.
- Stage 2 (edge k+1), only when v1=1:
  - s = p0 + p1, computed at 2W+1 bits with no intermediate overflow.
  - r = (s + 2^(FRAC-1)) >>> FRAC, arithmetic shift. This is round-half-toward-+infinity.
  - If r is outside [-2^(W-1), 2^(W-1)-1]:
    - ovf=1.
    - c = 2^(W-1)-1 (positive) or -2^(W-1) (negative) when SAT=1.
    - c = r[W-1:0] when SAT=0.
  - Otherwise c = r[W-1:0] and ovf=0.
  - Rounding is applied before the range check, so a value that rounds up past max saturates.
- out_valid is set to v1 every cycle.
- When v1=0, c and ovf hold their previous values.
- Inputs are ignored when in_valid=0.
- Most-negative operands (-2^(W-1) * -2^(W-1)) must not overflow the product register. The 2W-bit product is sufficient.

Decomposition:
- Shared package dot2_pkg:
  - Constants W_DEF=16, FRAC_DEF=8.
  - Q8.8 MAX=16'h7FFF, MIN=16'h8000, ONE=16'h0100.
  - Typedef for the signed W-bit word.
- Sub-module fxp_round_sat: combinational, wide signed input -> W-bit rounded/saturated output plus ovf flag. Parameters W, FRAC, SAT; the in width is 2W+1.
  - Reused by other fixed-point blocks.
- Multipliers and the adder stay inline.

Test Plan:
- Reset, then in_valid=1 with a0=a1=16'hFE80 (-1.5), b0=16'h0080 (0.5), b1=16'hFC80 (-3.5) -> 2 clocks later out_valid=1, c=16'h0480 (4.5), ovf=0.
- a0=a1=16'h00EB (0.918), b0=b1=16'h02EB (2.918) -> c=16'h055B (5.355), ovf=0.
- Rounding:
  - a0=16'h0001, b0=16'h0080, a1=b1=0 -> c=16'h0001.
  - Same with b0=16'h007F -> c=16'h0000.
  - a0=16'hFFFF, b0=16'h0080 -> c=16'h0000 (tie rounds toward +infinity).
- Saturation (SAT=1):
  - a0=a1=b0=b1=16'h7FFF -> c=16'h7FFF, ovf=1.
  - a0=a1=16'h8000, b0=b1=16'h7FFF -> c=16'h8000, ovf=1.
  - a0=b0=16'h8000, a1=b1=0 -> c=16'h7FFF, ovf=1.
- Streaming:
  - Three back-to-back valid sets, then a gap -> three consecutive out_valid pulses in order, then out_valid=0 with c held.
  - Assert rst in the cycle after the second input -> no output for the in-flight set; c=0, out_valid=0.

Source files
------------

// File: rtl/dot2_pkg.sv
// Shared fixed-point definitions for the dot2_q88 kernel and its helpers.
// Default format is Q8.8: 16-bit two's complement with 8 fractional bits.
package dot2_pkg;

  localparam int W_DEF    = 16;
  localparam int FRAC_DEF = 8;

  localparam logic [W_DEF-1:0] Q88_MAX = 16'h7FFF;
  localparam logic [W_DEF-1:0] Q88_MIN = 16'h8000;
  localparam logic [W_DEF-1:0] Q88_ONE = 16'h0100;

  typedef logic signed [W_DEF-1:0] word_t;

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up and narrow: wide signed value -> W-bit result
// with overflow flag; saturates or wraps depending on SAT.
module fxp_round_sat
  import dot2_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int SAT  = 1,
  parameter int IN_W = 2 * W + 1
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [W-1:0]    dout,
  output logic                   ovf
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int XW = IN_W + 1;

  localparam logic signed [XW-1:0] ONE_X = {{(XW-1){1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] HALF  = ONE_X << (FRAC - 1);
  localparam logic signed [XW-1:0] MAX_V = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_V = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [XW-1:0] biased;
  logic signed [XW-1:0] rounded;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    biased  = {din[IN_W-1], din} + HALF;
    rounded = biased >>> FRAC;
    dout    = rounded[W-1:0];
    ovf     = 1'b0;
    if (rounded > MAX_V) begin
      ovf = 1'b1;
      if (SAT != 0) dout = MAX_V[W-1:0];
    end else if (rounded < MIN_V) begin
      ovf = 1'b1;
      if (SAT != 0) dout = MIN_V[W-1:0];
    end
  end

endmodule

// File: rtl/dot2_q88.sv
// Two-stage pipelined signed fixed-point dot product c = a0*b0 + a1*b1,
// one result per clock, rounded to nearest and saturated (or wrapped).
module dot2_q88
  import dot2_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int FRAC = FRAC_DEF,
  parameter int SAT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] a0,
  input  logic signed [W-1:0] a1,
  input  logic signed [W-1:0] b0,
  input  logic signed [W-1:0] b1,
  output logic                out_valid,
  output logic signed [W-1:0] c,
  output logic                ovf
);

  logic signed [2*W-1:0] a0_x, a1_x, b0_x, b1_x;
  logic signed [2*W-1:0] p0_q, p1_q;
  logic                  v1_q;
  logic signed [2*W:0]   sum;
  logic signed [W-1:0]   c_rs;
  logic                  ovf_rs;

  // Sign-extend to 2W so the products are exact, including -2^(W-1) squared.
  assign a0_x = {{W{a0[W-1]}}, a0};
  assign a1_x = {{W{a1[W-1]}}, a1};
  assign b0_x = {{W{b0[W-1]}}, b0};
  assign b1_x = {{W{b1[W-1]}}, b1};

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order. The product registers are
  // left unreset: v1_q alone decides whether their contents are ever used.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        p0_q <= a0_x * b0_x;
        p1_q <= a1_x * b1_x;
      end
    end
  end

  assign sum = {p0_q[2*W-1], p0_q} + {p1_q[2*W-1], p1_q};

  fxp_round_sat #(
    .W    (W),
    .FRAC (FRAC),
    .SAT  (SAT),
    .IN_W (2 * W + 1)
  ) u_round_sat (
    .din  (sum),
    .dout (c_rs),
    .ovf  (ovf_rs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        c   <= c_rs;
        ovf <= ovf_rs;
      end
    end
  end

endmodule

// File: tb/tb_dot2_q88.sv
// Directed-vector bench for dot2_q88 (Q8.8, SAT=1): reset, arithmetic,
// rounding, saturation, streaming and reset flush of in-flight data.
module tb_dot2_q88;
  import dot2_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  word_t a0, a1, b0, b1;
  logic  out_valid;
  word_t c;
  logic  ovf;

  int n_cmp = 0;
  int n_err = 0;

  dot2_q88 #(.W(16), .FRAC(8), .SAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a0        (a0),
    .a1        (a1),
    .b0        (b0),
    .b1        (b1),
    .out_valid (out_valid),
    .c         (c),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input word_t x0, input word_t x1,
                       input word_t y0, input word_t y1);
    in_valid = v;
    a0 = x0;
    a1 = x1;
    b0 = y0;
    b1 = y1;
  endtask

  // One isolated operand set; returns the outputs seen two edges later.
  task automatic run_one(input word_t x0, input word_t x1, input word_t y0,
                         input word_t y1, output logic ov, output word_t cv,
                         output logic fv);
    drive(1'b1, x0, x1, y0, y1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step();
    ov = out_valid;
    cv = c;
    fv = ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step();
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (c !== 16'h0000) begin n_err++; $display("FAIL reset_c: got %h want 0000", c); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic ov, fv;
    word_t cv;
    run_one(16'hFE80, 16'hFE80, 16'h0080, 16'hFC80, ov, cv, fv);
    n_cmp++; if (ov !== 1'b1) begin n_err++; $display("FAIL basic1_valid: got %b want 1", ov); end
    n_cmp++; if (cv !== 16'h0480) begin n_err++; $display("FAIL basic1_c: got %h want 0480", cv); end
    n_cmp++; if (fv !== 1'b0) begin n_err++; $display("FAIL basic1_ovf: got %b want 0", fv); end
    run_one(16'h00EB, 16'h00EB, 16'h02EB, 16'h02EB, ov, cv, fv);
    n_cmp++; if (ov !== 1'b1) begin n_err++; $display("FAIL basic2_valid: got %b want 1", ov); end
    n_cmp++; if (cv !== 16'h055B) begin n_err++; $display("FAIL basic2_c: got %h want 055B", cv); end
    n_cmp++; if (fv !== 1'b0) begin n_err++; $display("FAIL basic2_ovf: got %b want 0", fv); end
  endtask

  task automatic test_rounding();
    logic ov, fv;
    word_t cv;
    run_one(16'h0001, 16'h0000, 16'h0080, 16'h0000, ov, cv, fv);
    n_cmp++; if (cv !== 16'h0001 || fv !== 1'b0) begin n_err++; $display("FAIL round_half_up: got c=%h ovf=%b want c=0001 ovf=0", cv, fv); end
    run_one(16'h0001, 16'h0000, 16'h007F, 16'h0000, ov, cv, fv);
    n_cmp++; if (cv !== 16'h0000 || fv !== 1'b0) begin n_err++; $display("FAIL round_below_half: got c=%h ovf=%b want c=0000 ovf=0", cv, fv); end
    run_one(16'hFFFF, 16'h0000, 16'h0080, 16'h0000, ov, cv, fv);
    n_cmp++; if (cv !== 16'h0000 || fv !== 1'b0) begin n_err++; $display("FAIL round_neg_tie: got c=%h ovf=%b want c=0000 ovf=0", cv, fv); end
  endtask

  task automatic test_saturation();
    logic ov, fv;
    word_t cv;
    run_one(Q88_MAX, Q88_MAX, Q88_MAX, Q88_MAX, ov, cv, fv);
    n_cmp++; if (cv !== 16'h7FFF || fv !== 1'b1) begin n_err++; $display("FAIL sat_pos: got c=%h ovf=%b want c=7FFF ovf=1", cv, fv); end
    run_one(Q88_MIN, Q88_MIN, Q88_MAX, Q88_MAX, ov, cv, fv);
    n_cmp++; if (cv !== 16'h8000 || fv !== 1'b1) begin n_err++; $display("FAIL sat_neg: got c=%h ovf=%b want c=8000 ovf=1", cv, fv); end
    run_one(Q88_MIN, 16'h0000, Q88_MIN, 16'h0000, ov, cv, fv);
    n_cmp++; if (cv !== 16'h7FFF || fv !== 1'b1) begin n_err++; $display("FAIL sat_min_sq: got c=%h ovf=%b want c=7FFF ovf=1", cv, fv); end
    // Saturated result followed by an in-range one must clear ovf.
    run_one(Q88_ONE, 16'h0000, Q88_ONE, 16'h0000, ov, cv, fv);
    n_cmp++; if (cv !== 16'h0100 || fv !== 1'b0) begin n_err++; $display("FAIL one_times_one: got c=%h ovf=%b want c=0100 ovf=0", cv, fv); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'hFE80, 16'hFE80, 16'h0080, 16'hFC80);
    step();
    drive(1'b1, 16'h00EB, 16'h00EB, 16'h02EB, 16'h02EB);
    step();
    n_cmp++; if (out_valid !== 1'b1 || c !== 16'h0480) begin n_err++; $display("FAIL b2b_first: got v=%b c=%h want v=1 c=0480", out_valid, c); end
    drive(1'b1, 16'h0001, 16'h0000, 16'h0080, 16'h0000);
    step();
    n_cmp++; if (out_valid !== 1'b1 || c !== 16'h055B) begin n_err++; $display("FAIL b2b_second: got v=%b c=%h want v=1 c=055B", out_valid, c); end
    // Garbage operands with in_valid low must be ignored.
    drive(1'b0, Q88_MAX, Q88_MAX, Q88_MAX, Q88_MAX);
    step();
    n_cmp++; if (out_valid !== 1'b1 || c !== 16'h0001) begin n_err++; $display("FAIL b2b_third: got v=%b c=%h want v=1 c=0001", out_valid, c); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || c !== 16'h0001 || ovf !== 1'b0) begin n_err++; $display("FAIL b2b_hold: got v=%b c=%h ovf=%b want v=0 c=0001 ovf=0", out_valid, c, ovf); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || c !== 16'h0001) begin n_err++; $display("FAIL b2b_hold2: got v=%b c=%h want v=0 c=0001", out_valid, c); end
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset_flush();
    drive(1'b1, 16'h00EB, 16'h00EB, 16'h02EB, 16'h02EB);
    step();
    drive(1'b1, 16'hFE80, 16'hFE80, 16'h0080, 16'hFC80);
    step();
    n_cmp++; if (out_valid !== 1'b1 || c !== 16'h055B) begin n_err++; $display("FAIL flush_first: got v=%b c=%h want v=1 c=055B", out_valid, c); end
    // Reset wins over a simultaneous valid operand set.
    rst = 1'b1;
    drive(1'b1, Q88_MAX, Q88_MAX, Q88_MAX, Q88_MAX);
    step();
    n_cmp++; if (out_valid !== 1'b0 || c !== 16'h0000 || ovf !== 1'b0) begin n_err++; $display("FAIL flush_reset: got v=%b c=%h ovf=%b want v=0 c=0000 ovf=0", out_valid, c, ovf); end
    rst = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    step();
    n_cmp++; if (out_valid !== 1'b0 || c !== 16'h0000) begin n_err++; $display("FAIL flush_after: got v=%b c=%h want v=0 c=0000", out_valid, c); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || c !== 16'h0000) begin n_err++; $display("FAIL flush_after2: got v=%b c=%h want v=0 c=0000", out_valid, c); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
